// File: rtl/aes_encrypt_core.sv
// Iterative AES encryption core: one round per clock over a 128-bit state.
// Round keys come from an external key store addressed by Addr. The store
// answers on Key, with Key[128] flagging that the presented key is valid.
// FIPS-197 byte n sits at bits [8n+7:8n]; column c holds bytes 4c..4c+3,
// and byte 4c+r is row r of that column.
module aes_encrypt_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         t_ready,
    input  logic [127:0] plaintext,
    input  logic [3:0]   Nr,
    input  logic [128:0] Key,
    input  logic         op,
    output logic [3:0]   Addr,
    output logic         Core_Busy,
    output logic         c_ready,
    output logic [127:0] Ciphertext
);

    // The S-box is stored with entry 0 in the top byte, so entry x sits at
    // packed index 255-x. For an 8-bit x, 255-x is simply ~x.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE,
        ROUND
    } fsm_e;

    // Multiply by x in GF(2^8) with the reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    fsm_e         fsm_q;
    logic [127:0] stateData_q;
    logic [3:0]   round_q;
    logic [3:0]   nrLatched_q;
    logic         busy_q;
    logic         cReady_q;
    logic [127:0] cipher_q;

    logic [7:0]   subB   [16];
    logic [7:0]   shiftB [16];
    logic [127:0] midRound_d;
    logic [127:0] lastRound_d;

    logic         keyValid;
    logic [127:0] roundKey;

    assign keyValid = Key[128];
    assign roundKey = Key[127:0];

    // Round datapath: SubBytes, then ShiftRows, then MixColumns.
    // The final round skips MixColumns and uses the ShiftRows output directly.
    for (genvar n = 0; n < 16; n++) begin : g_sub
        assign subB[n] = SBOX[~stateData_q[8*n +: 8]];
    end

    // ShiftRows rotates row r left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_shift_col
        for (genvar r = 0; r < 4; r++) begin : g_shift_row
            assign shiftB[4*c + r] = subB[4*((c + r) % 4) + r];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;

        assign a0 = shiftB[4*c];
        assign a1 = shiftB[4*c + 1];
        assign a2 = shiftB[4*c + 2];
        assign a3 = shiftB[4*c + 3];

        assign b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

        assign midRound_d[32*c +: 32]  = {b3, b2, b1, b0} ^ roundKey[32*c +: 32];
        assign lastRound_d[32*c +: 32] = {a3, a2, a1, a0} ^ roundKey[32*c +: 32];
    end

    // Control FSM. It accepts a block, runs one round per valid key, and
    // publishes the result with a one-cycle c_ready. The round counter
    // doubles as the key-store address, and it is zero whenever the core is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            stateData_q <= '0;
            round_q     <= '0;
            nrLatched_q <= '0;
            busy_q      <= 1'b0;
            cReady_q    <= 1'b0;
            cipher_q    <= '0;
        end else begin
            cReady_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (t_ready && op && keyValid && (Nr != 4'd0)) begin
                        stateData_q <= plaintext ^ roundKey;
                        nrLatched_q <= Nr;
                        round_q     <= 4'd1;
                        busy_q      <= 1'b1;
                        fsm_q       <= ROUND;
                    end
                end
                ROUND: begin
                    if (keyValid) begin
                        if (round_q == nrLatched_q) begin
                            cipher_q <= lastRound_d;
                            cReady_q <= 1'b1;
                            busy_q   <= 1'b0;
                            round_q  <= 4'd0;
                            fsm_q    <= IDLE;
                        end else begin
                            stateData_q <= midRound_d;
                            round_q     <= round_q + 4'd1;
                        end
                    end
                end
                default: begin
                    fsm_q   <= IDLE;
                    round_q <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Addr       = round_q;
    assign Core_Busy  = busy_q;
    assign c_ready    = cReady_q;
    assign Ciphertext = cipher_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed bench for aes_encrypt_core. It uses the FIPS-197 App. B and
// App. C.1 AES-128 vectors, with hand-copied key schedules served by a
// small key-store model that answers on Addr.
module tb_aes_encrypt_core;

    localparam logic [127:0] PT1 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] CT1 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

    logic         clock = 1'b0;
    logic         resetN;
    logic         tReady;
    logic         opEn;
    logic         keyValid;
    logic [127:0] plainText;
    logic [3:0]   nrIn;
    logic [128:0] keyBus;
    logic [3:0]   addr;
    logic         coreBusy;
    logic         cReady;
    logic [127:0] cipherText;

    int           keySel;
    logic [127:0] keyTable [2][11];
    logic [127:0] pt2;
    logic [127:0] ct2;
    int           vectors = 0;
    int           miscompares = 0;
    int           edges;

    aes_encrypt_core dut (
        .clk        (clock),
        .rst_n      (resetN),
        .t_ready    (tReady),
        .plaintext  (plainText),
        .Nr         (nrIn),
        .Key        (keyBus),
        .op         (opEn),
        .Addr       (addr),
        .Core_Busy  (coreBusy),
        .c_ready    (cReady),
        .Ciphertext (cipherText)
    );

    // Free-running clock with a 10-unit period.
    always #5 clock = ~clock;

    // External round-key store. It answers the requested index at once.
    assign keyBus = {keyValid, (addr <= 4'd10) ? keyTable[keySel][addr] : 128'h0};

    // The FIPS-197 documents list bytes in input order; the port puts byte 0 in the LSB.
    function automatic logic [127:0] swapBytes(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15 - i) +: 8];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] pt, input int sel, input logic [3:0] nr);
        plainText = pt;
        keySel    = sel;
        nrIn      = nr;
        tReady    = 1'b1;
    endtask

    // Count negedges until c_ready shows, giving up after the budget.
    task automatic waitCReady(input int budget, output int count);
        count = 0;
        do begin
            @(negedge clock);
            count++;
        end while (!cReady && count < budget);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        resetN    = 1'b0;
        tReady    = 1'b0;
        opEn      = 1'b0;
        keyValid  = 1'b1;
        keySel    = 0;
        plainText = '0;
        nrIn      = 4'd10;

        keyTable[0][0]  = swapBytes(128'h000102030405060708090a0b0c0d0e0f);
        keyTable[0][1]  = swapBytes(128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        keyTable[0][2]  = swapBytes(128'hb692cf0b643dbdf1be9bc5006830b3fe);
        keyTable[0][3]  = swapBytes(128'hb6ff744ed2c2c9bf6c590cbf0469bf41);
        keyTable[0][4]  = swapBytes(128'h47f7f7bc95353e03f96c32bcfd058dfd);
        keyTable[0][5]  = swapBytes(128'h3caaa3e8a99f9deb50f3af57adf622aa);
        keyTable[0][6]  = swapBytes(128'h5e390f7df7a69296a7553dc10aa31f6b);
        keyTable[0][7]  = swapBytes(128'h14f9701ae35fe28c440adf4d4ea9c026);
        keyTable[0][8]  = swapBytes(128'h47438735a41c65b9e016baf4aebf7ad2);
        keyTable[0][9]  = swapBytes(128'h549932d1f08557681093ed9cbe2c974e);
        keyTable[0][10] = swapBytes(128'h13111d7fe3944a17f307a78b4d2b30c5);

        keyTable[1][0]  = swapBytes(128'h2b7e151628aed2a6abf7158809cf4f3c);
        keyTable[1][1]  = swapBytes(128'ha0fafe1788542cb123a339392a6c7605);
        keyTable[1][2]  = swapBytes(128'hf2c295f27a96b9435935807a7359f67f);
        keyTable[1][3]  = swapBytes(128'h3d80477d4716fe3e1e237e446d7a883b);
        keyTable[1][4]  = swapBytes(128'hef44a541a8525b7fb671253bdb0bad00);
        keyTable[1][5]  = swapBytes(128'hd4d1c6f87c839d87caf2b8bc11f915bc);
        keyTable[1][6]  = swapBytes(128'h6d88a37a110b3efddbf98641ca0093fd);
        keyTable[1][7]  = swapBytes(128'h4e54f70e5f5fc9f384a64fb24ea6dc4f);
        keyTable[1][8]  = swapBytes(128'head27321b58dbad2312bf5607f8d292f);
        keyTable[1][9]  = swapBytes(128'hac7766f319fadc2128d12941575c006e);
        keyTable[1][10] = swapBytes(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        pt2 = swapBytes(128'h3243f6a8885a308d313198a2e0370734);
        ct2 = swapBytes(128'h3925841d02dc09fbdc118597196a0b32);

        // Reset state, seen after one clock edge with reset held.
        @(negedge clock);
        checkOutput("reset addr", 128'(addr), 128'(0));
        checkOutput("reset busy", 128'(coreBusy), 128'(0));
        checkOutput("reset c_ready", 128'(cReady), 128'(0));
        checkOutput("reset ciphertext", cipherText, 128'h0);
        resetN = 1'b1;

        // op low: a start request must be ignored.
        opEn = 1'b0;
        applyStimulus(PT1, 0, 4'd10);
        repeat (3) begin
            @(negedge clock);
            checkOutput("op0 busy", 128'(coreBusy), 128'(0));
            checkOutput("op0 addr", 128'(addr), 128'(0));
        end

        // Nr of zero is not a valid start.
        opEn = 1'b1;
        nrIn = 4'd0;
        repeat (2) begin
            @(negedge clock);
            checkOutput("nr0 busy", 128'(coreBusy), 128'(0));
        end
        tReady = 1'b0;
        nrIn   = 4'd10;

        // C.1 vector in lockstep. Addr must step 1..10, and a second
        // request raised while busy must be ignored.
        applyStimulus(PT1, 0, 4'd10);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 1) tReady = 1'b0;
            if (k == 4) tReady = 1'b1;
            if (k == 6) tReady = 1'b0;
            checkOutput("seq addr", 128'(addr), 128'(k));
            checkOutput("seq busy", 128'(coreBusy), 128'(1));
            checkOutput("seq c_ready early", 128'(cReady), 128'(0));
        end
        @(negedge clock);
        checkOutput("c1 c_ready", 128'(cReady), 128'(1));
        checkOutput("c1 busy done", 128'(coreBusy), 128'(0));
        checkOutput("c1 addr done", 128'(addr), 128'(0));
        checkOutput("c1 ciphertext", cipherText, CT1);
        repeat (3) begin
            @(negedge clock);
            checkOutput("c1 single pulse", 128'(cReady), 128'(0));
            checkOutput("c1 no restart", 128'(coreBusy), 128'(0));
            checkOutput("c1 ciphertext hold", cipherText, CT1);
        end

        // App. B vector. Nr is changed and op dropped mid-block; both must be ignored.
        applyStimulus(pt2, 1, 4'd10);
        @(negedge clock);
        tReady = 1'b0;
        nrIn   = 4'd3;
        opEn   = 1'b0;
        waitCReady(30, edges);
        checkOutput("midchange latency", 128'(edges), 128'(10));
        checkOutput("midchange ciphertext", cipherText, ct2);
        opEn = 1'b1;
        nrIn = 4'd10;

        // Key stall: Key[128] is low for 3 cycles while Addr is 5.
        applyStimulus(PT1, 0, 4'd10);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k == 1) tReady = 1'b0;
        end
        checkOutput("stall addr before", 128'(addr), 128'(5));
        keyValid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            checkOutput("stall addr hold", 128'(addr), 128'(5));
            checkOutput("stall c_ready", 128'(cReady), 128'(0));
        end
        keyValid = 1'b1;
        waitCReady(30, edges);
        checkOutput("stall latency", 128'(edges), 128'(6));
        checkOutput("stall ciphertext", cipherText, CT1);

        // Asynchronous reset while Addr is 4.
        applyStimulus(pt2, 1, 4'd10);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            if (k == 1) tReady = 1'b0;
        end
        checkOutput("rst addr before", 128'(addr), 128'(4));
        #1;
        resetN = 1'b0;
        #1;
        checkOutput("rst addr", 128'(addr), 128'(0));
        checkOutput("rst busy", 128'(coreBusy), 128'(0));
        checkOutput("rst c_ready", 128'(cReady), 128'(0));
        checkOutput("rst ciphertext", cipherText, 128'h0);
        @(negedge clock);
        resetN = 1'b1;
        repeat (12) begin
            @(negedge clock);
            checkOutput("rst no result", 128'(cReady), 128'(0));
        end
        applyStimulus(PT1, 0, 4'd10);
        @(negedge clock);
        tReady = 1'b0;
        waitCReady(30, edges);
        checkOutput("after rst latency", 128'(edges), 128'(10));
        checkOutput("after rst ciphertext", cipherText, CT1);

        // Back-to-back: t_ready is held high across two blocks.
        applyStimulus(PT1, 0, 4'd10);
        waitCReady(30, edges);
        checkOutput("b2b first latency", 128'(edges), 128'(11));
        checkOutput("b2b first ciphertext", cipherText, CT1);
        plainText = pt2;
        keySel    = 1;
        @(negedge clock);
        checkOutput("b2b restart busy", 128'(coreBusy), 128'(1));
        checkOutput("b2b restart addr", 128'(addr), 128'(1));
        tReady = 1'b0;
        waitCReady(30, edges);
        checkOutput("b2b second latency", 128'(edges), 128'(10));
        checkOutput("b2b second ciphertext", cipherText, ct2);
        @(negedge clock);
        checkOutput("b2b idle", 128'(coreBusy), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_encrypt_core.md
Name: aes_encrypt_core

Overview:
- Iterative AES encryption datapath: one round per clock, 128-bit state register.
- Round keys are not expanded internally. They are fetched from an external round-key store through an index output (`Addr`) and a key-plus-valid input (`Key`).
- Sits between the text-input interface (`t_ready` / `plaintext`) and the ciphertext consumer (`c_ready` / `Ciphertext`).
- Round count `Nr` is supplied per block, so a 128/192/256-bit key store can drive the same core.

Parameters:
- None. All widths are fixed: 128-bit state, 4-bit round index.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `t_ready` in 1: plaintext valid / start request.
- `plaintext` in 128: input block.
- `Nr` in 4: number of rounds for this block (10, 12 or 14 nominal).
- `Key` in 129: bit 128 = round-key valid; bits 127:0 = round key `Addr`.
- `op` in 1: core enable. 1 = starts accepted; 0 = starts ignored. An in-flight block always finishes.
- `Addr` out 4: index of the round key currently required.
- `Core_Busy` out 1: high while a block is in flight.
- `c_ready` out 1: one-cycle pulse, `Ciphertext` valid.
- `Ciphertext` out 128: output block, registered.

Behaviour:
- Byte order on `plaintext`, `Key[127:0]` and `Ciphertext`:
  - FIPS-197 byte n (n = 0..15, input order) occupies bits [8n+7:8n]. Byte 0 is the LSB byte.
  - Column c = bytes 4c..4c+3; byte 4c+r is row r.
- Reset (async, `rst_n` = 0):
  - `Addr` = 0, `Core_Busy` = 0, `c_ready` = 0, `Ciphertext` = 0.
  - State and round counter cleared. Any in-flight block is discarded with no `c_ready`.
- States: IDLE, ROUND.
- IDLE:
  - `Addr` = 0.
  - Start condition: `t_ready` & `op` & `Key[128]` & (`Nr` != 0).
  - On the start edge: state <= `plaintext` XOR `Key[127:0]` (initial AddRoundKey); latch `Nr`; round counter r <= 1; `Addr` <= 1; `Core_Busy` <= 1; go to ROUND.
  - If `Key[128]` = 0, the start waits; `t_ready` must stay high.
- ROUND (`Addr` = r):
  - Edge with `Key[128]` = 1 and r < Nr: state <= MixColumns(ShiftRows(SubBytes(state))) XOR `Key[127:0]`; r and `Addr` increment.
  - Edge with `Key[128]` = 1 and r = Nr (final round, no MixColumns):
    - `Ciphertext` <= ShiftRows(SubBytes(state)) XOR `Key[127:0]`.
    - `c_ready` <= 1 for exactly one cycle; `Core_Busy` <= 0; `Addr` <= 0; go to IDLE.
  - `Key[128]` = 0: stall. State, r and `Addr` hold.
- Latency with the key always valid:
  - Start edge E0; `c_ready` high in the cycle after edge E0+Nr.
  - 10 rounds → 11 clock edges from accept to result.
- Back-to-back operation:
  - `t_ready` is ignored while `Core_Busy` = 1.
  - A new start is accepted on the edge after `c_ready` at the earliest.
  - `t_ready` held high restarts automatically on that edge.
- `Ciphertext` holds its value until the next completed block.
- `Nr` is sampled only at start; changes mid-block are ignored.
- `op` falling mid-block does not abort the block.
- SubBytes: standard AES S-box. Either a 256-entry table or a composite-field implementation is acceptable. It must be combinational within one cycle.
- MixColumns over GF(2^8), polynomial 0x11B.

Test Plan:
- FIPS-197 App. C.1 vector:
  - Stimulus: key port = 128'h0f0e0d0c0b0a09080706050403020100, plaintext = 128'hffeeddccbbaa99887766554433221100, `Nr` = 10, `op` = 1, `t_ready` pulse; bench serves expanded round keys on `Addr`.
  - Required: `Ciphertext` = 128'h5ac5b47080b7cdd830047b6ad8e0c469; `c_ready` high for exactly one cycle, 11 edges after accept.
- Addr/Busy sequencing on the same run: `Addr` steps 0, 1, 2 … 10, then back to 0; `Core_Busy` is high from accept until the `c_ready` cycle.
- Key stall: drop `Key[128]` for 3 cycles at `Addr` = 5 → `Addr` holds at 5; ciphertext unchanged; `c_ready` delayed by 3 cycles.
- Enable and busy gating:
  - `t_ready` = 1 with `op` = 0 → no start: `Core_Busy` stays 0, `Addr` stays 0.
  - Second `t_ready` while busy → ignored; one result only.
- Reset mid-operation: assert `rst_n` = 0 at round 4 → all outputs go to 0 immediately, no `c_ready`. A new block after release gives a correct result.
- Back-to-back: `t_ready` held high for two blocks → starts 11 cycles apart; both ciphertexts match the software AES model.
